// File: rtl/axis_rr_packet_arbiter.sv
// axis_rr_packet_arbiter: packet-level round-robin mux of NUM AXI-stream sources onto one master port.
// A grant is taken only between packets and held until the granted source's tlast handshake.
module axis_rr_packet_arbiter #(
  parameter int NUM = 4,
  parameter int DSIZE = 8,
  localparam int IW = $clog2(NUM),
  localparam int KSIZE = (DSIZE + 7) / 8
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NUM-1:0]       s_axis_tvalid,
  output logic [NUM-1:0]       s_axis_tready,
  input  logic [NUM*DSIZE-1:0] s_axis_tdata,
  input  logic [NUM-1:0]       s_axis_tlast,
  input  logic [NUM*KSIZE-1:0] s_axis_tkeep,
  input  logic [NUM-1:0]       s_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [DSIZE-1:0]     m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic [KSIZE-1:0]     m_axis_tkeep,
  output logic                 m_axis_tuser,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic [15:0]          pkt_cnt
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [IW-1:0] last_ptr, pick, idx;
  logic done;
  // Scan downward so the nearest requester after last_ptr wins.
  always_comb begin
    pick = last_ptr;
    idx = '0;
    for (int k = NUM; k >= 1; k--) begin
      idx = IW'((int'(last_ptr) + k) % NUM);
      if (s_axis_tvalid[idx]) pick = idx;
    end
  end
  assign busy          = state == BUSY;
  assign m_axis_tvalid = busy && s_axis_tvalid[grant_id];
  assign m_axis_tdata  = s_axis_tdata[grant_id*DSIZE +: DSIZE];
  assign m_axis_tkeep  = s_axis_tkeep[grant_id*KSIZE +: KSIZE];
  assign m_axis_tlast  = s_axis_tlast[grant_id];
  assign m_axis_tuser  = s_axis_tuser[grant_id];
  assign s_axis_tready = busy ? NUM'(m_axis_tready) << grant_id : '0;
  assign done          = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  always_comb begin
    state_nx = state;
    state_nx = busy ? (done ? IDLE : BUSY) : (|s_axis_tvalid ? BUSY : IDLE);
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      last_ptr <= IW'(NUM - 1);
      pkt_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (!busy && |s_axis_tvalid) grant_id <= pick;
      if (done) begin
        last_ptr <= grant_id;
        pkt_cnt  <= pkt_cnt + 16'd1;
      end
    end
  end
endmodule
